// File: rtl/ahb_sram_pkg.sv
// Shared encodings, error-FSM state type and byte-lane mask helper for ahb_sram_bridge.
package ahb_sram_pkg;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    localparam logic [2:0] SizeByte = 3'd0;
    localparam logic [2:0] SizeHalf = 3'd1;
    localparam logic [2:0] SizeWord = 3'd2;

    typedef enum logic [1:0] {
        OKAY = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } err_state_e;

    // Sizes above a word fall into the default and enable all four lanes.
    function automatic logic [3:0] byte_mask(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (hsize)
            SizeByte: mask = 4'b0001 << addr_lo;
            SizeHalf: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:  mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_err_fsm.sv
// Two-cycle AHB ERROR response sequencer; drives the slave's HREADYOUT and HRESP.
module ahb_sram_err_fsm
    import ahb_sram_pkg::*;
(
    input  logic CLK,
    input  logic RSTn,
    input  logic err_req_i,
    output logic hreadyout_o,
    output logic hresp_o
);

    err_state_e state_q, state_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= OKAY;
        end else begin
            state_q <= state_d;
        end
    end

    // An illegal transfer accepted during ERR2 starts a fresh error response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OKAY:    state_d = err_req_i ? ERR1 : OKAY;
            ERR1:    state_d = ERR2;
            ERR2:    state_d = err_req_i ? ERR1 : OKAY;
            default: state_d = OKAY;
        endcase
    end

    always_comb begin
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        unique case (state_q)
            OKAY: begin
                hreadyout_o = 1'b1;
                hresp_o     = 1'b0;
            end
            ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
            end
            ERR2: begin
                hreadyout_o = 1'b1;
                hresp_o     = 1'b1;
            end
            default: begin
                hreadyout_o = 1'b1;
                hresp_o     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_bridge.sv
// Zero-wait-state AHB-Lite to SRAM bridge. Define AHB_SRAM_BRIDGE_CHECK_EN to enable
// size/alignment/window checking with a two-cycle ERROR response.
module ahb_sram_bridge
    import ahb_sram_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 16,
    parameter logic [31:0] MEMBASE   = 32'h0000_0000
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic                 HWRITE,
    input  logic                 HREADY,
    input  logic [31:0]          HWDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic [ADDRWIDTH-1:0] SRAMADDR,
    output logic                 SRAMCS,
    output logic [3:0]           SRAMWE,
    output logic [31:0]          SRAMWDATA,
    input  logic [31:0]          SRAMRDATA
);

    logic accept;
    logic illegal;
    logic accept_ok;

    logic                 dp_valid_q, dp_valid_d;
    logic                 dp_write_q, dp_write_d;
    logic [ADDRWIDTH-1:0] dp_addr_q, dp_addr_d;
    logic [3:0]           dp_mask_q, dp_mask_d;

    assign accept = HSEL & HTRANS[1] & HREADY;

`ifdef AHB_SRAM_BRIDGE_CHECK_EN
    always_comb begin
        illegal = 1'b0;
        if (HSIZE > SizeWord) begin
            illegal = 1'b1;
        end
        if ((HSIZE == SizeHalf) && HADDR[0]) begin
            illegal = 1'b1;
        end
        if ((HSIZE == SizeWord) && (HADDR[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
        if (HADDR[31:ADDRWIDTH+2] != MEMBASE[31:ADDRWIDTH+2]) begin
            illegal = 1'b1;
        end
    end

    logic unused_sig;
    assign unused_sig = HTRANS[0];
`else
    assign illegal = 1'b0;

    // Upper address bits are dropped so the SRAM window aliases across the address map.
    logic unused_sig;
    assign unused_sig = ^{HTRANS[0], HADDR[31:ADDRWIDTH+2], MEMBASE};
`endif

    assign accept_ok = accept & ~illegal;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_mask_q  <= 4'b0000;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            dp_mask_q  <= dp_mask_d;
        end
    end

    always_comb begin
        dp_valid_d = accept_ok;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        dp_mask_d  = dp_mask_q;
        if (accept_ok) begin
            dp_write_d = HWRITE;
            dp_addr_d  = HADDR[ADDRWIDTH+1:2];
            dp_mask_d  = byte_mask(HSIZE, HADDR[1:0]);
        end
    end

    assign SRAMCS    = dp_valid_q;
    assign SRAMADDR  = dp_addr_q;
    assign SRAMWE    = (dp_valid_q && dp_write_q) ? dp_mask_q : 4'b0000;
    assign SRAMWDATA = HWDATA;
    assign HRDATA    = dp_valid_q ? SRAMRDATA : 32'h0000_0000;

    ahb_sram_err_fsm u_err_fsm (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .err_req_i   (accept & illegal),
        .hreadyout_o (HREADYOUT),
        .hresp_o     (HRESP)
    );

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Scoreboard bench for ahb_sram_bridge: a byte-level memory model predicts every data phase.
module tb_ahb_sram_bridge;

    localparam int unsigned AW = 16;
`ifdef AHB_SRAM_BRIDGE_CHECK_EN
    localparam logic [31:0] MEMBASE = 32'h2000_0000;
`else
    localparam logic [31:0] MEMBASE = 32'h0000_0000;
`endif
    localparam longint unsigned WIN = 64'd1 << (AW + 2);

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic          HREADY;
    logic [31:0]   HWDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] SRAMADDR;
    logic          SRAMCS;
    logic [3:0]    SRAMWE;
    logic [31:0]   SRAMWDATA;
    logic [31:0]   SRAMRDATA;

    always #5 CLK = ~CLK;

    // Single-slave bus: the slave's ready is the bus ready.
    assign HREADY = HREADYOUT;

    ahb_sram_bridge #(
        .ADDRWIDTH (AW),
        .MEMBASE   (MEMBASE)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .SRAMADDR  (SRAMADDR),
        .SRAMCS    (SRAMCS),
        .SRAMWE    (SRAMWE),
        .SRAMWDATA (SRAMWDATA),
        .SRAMRDATA (SRAMRDATA)
    );

    // Flat SRAM: combinational read, lane writes commit on the rising edge.
    logic [31:0] sram [2**AW];
    initial for (int i = 0; i < 2**AW; i++) sram[i] = 32'h0;
    assign SRAMRDATA = sram[SRAMADDR];
    always @(posedge CLK) begin
        if (SRAMCS) begin
            for (int l = 0; l < 4; l++) begin
                if (SRAMWE[l]) sram[SRAMADDR][8*l +: 8] <= SRAMWDATA[8*l +: 8];
            end
        end
    end

    typedef struct {
        bit          is_err;
        bit          is_read;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  model [int unsigned];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] wdata_nxt = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit ref_illegal(input logic [31:0] a, input logic [2:0] sz);
`ifdef AHB_SRAM_BRIDGE_CHECK_EN
        logic [31:0] mb;
        mb = MEMBASE;
        return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) ||
               (a[31:AW+2] != mb[31:AW+2]);
`else
        return (a == 32'hFFFF_FFFF) && (sz == 3'd7) && 1'b0;
`endif
    endfunction

    function automatic logic [7:0] mget(input longint unsigned b);
        int unsigned k;
        k = int'(b % WIN);
        return model.exists(k) ? model[k] : 8'h00;
    endfunction

    // Present one transfer, wait for its address phase to be taken, then log its expectation.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input bit commit);
        exp_t            e;
        bit              rdy;
        int              waits;
        longint unsigned n, start, wbase;
        HSEL   = 1'b1;
        HTRANS = {1'b1, 1'($urandom_range(0, 1))};
        HADDR  = a;
        HSIZE  = sz;
        HWRITE = wr;
        HWDATA = wdata_nxt;
        waits  = 0;
        do begin
            @(negedge CLK);
            rdy = HREADYOUT;
            @(posedge CLK);
            #1;
            waits++;
        end while (!rdy && waits < 8);
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL accept_timeout: ready %0b required 1", rdy);
        end
        n       = (sz >= 3'd2) ? 4 : (64'd1 << sz);
        start   = longint'(a) - (longint'(a) % n);
        wbase   = (start % WIN) - ((start % WIN) % 4);
        e.is_err  = ref_illegal(a, sz);
        e.is_read = !wr;
        e.addr    = 32'(wbase / 4);
        e.we      = 4'b0000;
        for (longint unsigned k = 0; k < n; k++) begin
            if (wr) e.we[int'((start + k) % 4)] = 1'b1;
        end
        e.rdata = {mget(wbase + 3), mget(wbase + 2), mget(wbase + 1), mget(wbase)};
        sbq.push_back(e);
        if (wr && commit && !e.is_err) begin
            for (int l = 0; l < 4; l++) begin
                if (e.we[l]) model[int'(wbase) + l] = wd[8*l +: 8];
            end
        end
        wdata_nxt = wd;
    endtask

    task automatic idle(input int cycles);
        HSEL   = 1'($urandom_range(0, 1));
        HTRANS = HSEL ? {1'b0, 1'($urandom_range(0, 1))} : 2'($urandom_range(0, 3));
        HADDR  = $urandom;
        HWRITE = 1'($urandom_range(0, 1));
        HWDATA = wdata_nxt;
        repeat (cycles) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: checks each data-phase cycle against the front of the scoreboard.
    initial begin
        bit   pending = 1'b0;
        bit   err_seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
                chk("rst_hresp", 32'(HRESP), 32'd0);
                chk("rst_sramcs", 32'(SRAMCS), 32'd0);
                chk("rst_sramwe", 32'(SRAMWE), 32'd0);
                chk("rst_sramaddr", 32'(SRAMADDR), 32'd0);
                chk("rst_hrdata", HRDATA, 32'd0);
                sbq.delete();
                pending  = 1'b0;
                err_seen = 1'b0;
            end else begin
                if (pending && sbq.size() == 0) begin
                    chk("sb_nonempty", 32'(sbq.size()), 32'd1);
                end else if (pending && !HREADYOUT) begin
                    chk("err1_kind", 32'(sbq[0].is_err), 32'd1);
                    chk("err1_hresp", 32'(HRESP), 32'd1);
                    chk("err1_sramcs", 32'(SRAMCS), 32'd0);
                    err_seen = 1'b1;
                end else if (pending) begin
                    e = sbq.pop_front();
                    if (e.is_err) begin
                        chk("err2_first_seen", 32'(err_seen), 32'd1);
                        chk("err2_hresp", 32'(HRESP), 32'd1);
                        chk("err2_sramcs", 32'(SRAMCS), 32'd0);
                    end else begin
                        chk("dp_hresp", 32'(HRESP), 32'd0);
                        chk("dp_sramcs", 32'(SRAMCS), 32'd1);
                        chk("dp_sramaddr", 32'(SRAMADDR), e.addr);
                        chk("dp_sramwe", 32'(SRAMWE), 32'(e.we));
                        if (e.is_read) chk("dp_hrdata", HRDATA, e.rdata);
                    end
                    err_seen = 1'b0;
                end else begin
                    chk("idle_hreadyout", 32'(HREADYOUT), 32'd1);
                    chk("idle_hresp", 32'(HRESP), 32'd0);
                    chk("idle_sramcs", 32'(SRAMCS), 32'd0);
                    chk("idle_hrdata", HRDATA, 32'd0);
                end
                if (HREADYOUT) pending = HSEL & HTRANS[1];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        RSTn   = 1'b0;
        HSEL   = 1'b0;
        HADDR  = 32'h0;
        HTRANS = 2'b00;
        HSIZE  = 3'd0;
        HWRITE = 1'b0;
        HWDATA = 32'h0;
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;

        // Word write/read, byte merge, back-to-back write then read.
        xfer(1'b1, MEMBASE + 32'h10, 3'd2, 32'hDEAD_BEEF, 1'b1);
        xfer(1'b0, MEMBASE + 32'h10, 3'd2, 32'h0, 1'b1);
        xfer(1'b1, MEMBASE + 32'h10, 3'd2, 32'h1122_3344, 1'b1);
        xfer(1'b1, MEMBASE + 32'h13, 3'd0, 32'hAA00_0000, 1'b1);
        xfer(1'b0, MEMBASE + 32'h10, 3'd2, 32'h0, 1'b1);
        xfer(1'b1, MEMBASE + 32'h20, 3'd2, 32'h0000_0005, 1'b1);
        xfer(1'b0, MEMBASE + 32'h20, 3'd2, 32'h0, 1'b1);
        idle(2);

        // Reset in the data phase of a write: the word must keep its old value.
        xfer(1'b1, MEMBASE + 32'h40, 3'd2, 32'hCAFE_F00D, 1'b1);
        idle(2);
        xfer(1'b1, MEMBASE + 32'h40, 3'd2, 32'h1234_5678, 1'b0);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = 32'h1234_5678;
        #2 RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;
        xfer(1'b0, MEMBASE + 32'h40, 3'd2, 32'h0, 1'b1);
        idle(2);

`ifdef AHB_SRAM_BRIDGE_CHECK_EN
        xfer(1'b1, MEMBASE + 32'h04, 3'd2, 32'h0BAD_F00D, 1'b1);
        xfer(1'b1, MEMBASE + 32'h01, 3'd1, 32'h0000_5566, 1'b1);
        idle(4);
        xfer(1'b0, 32'h3000_0000, 3'd2, 32'h0, 1'b1);
        xfer(1'b0, MEMBASE + 32'h04, 3'd2, 32'h0, 1'b1);
        idle(2);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle(int'($urandom_range(1, 2)));
            end else begin
                a  = MEMBASE + 32'($urandom_range(0, 63));
                if ($urandom_range(0, 15) == 0) a = a ^ 32'h4000_0000;
                sz = 3'($urandom_range(0, 3));
                xfer(1'($urandom_range(0, 1)), a, sz, $urandom, 1'b1);
            end
        end
        idle(4);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
